// File: rtl/dfe_hb_pkg.sv
// dfe_hb_pkg
// Shared definitions for the halfband decimator stage of the DFE chain:
// the FSM state type, the filter geometry and the power-up coefficient set.
// The coefficient set is a symmetric halfband design with DC gain of 1.0
// (S20.18): centre tap 0.5, and the six outer taps together sum to 0.25.
package dfe_hb_pkg;

    localparam int N_TAP      = 23;
    localparam int N_UNIQ     = 7;
    localparam int FIFO_DEPTH = 4;
    localparam int HB_COEFF_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } hb_state_t;

    // Entry k (k<6) weights taps 2k and 22-2k; entry 6 weights the centre tap 11.
    localparam logic signed [HB_COEFF_WIDTH-1:0] DEFAULT_COEFF [N_UNIQ] = '{
        -20'sd564,
         20'sd2600,
        -20'sd5500,
         20'sd12000,
        -20'sd25000,
         20'sd82000,
         20'sh20000
    };

endpackage

// File: rtl/rounding_overflow_arith.sv
// rounding_overflow_arith
// Converts a wide fixed-point accumulator to the output sample format:
// round half-up at the output LSB, then saturate to the signed output range.
// Ports:
//   acc_in    in   ACC_WIDTH  signed accumulator, ACC_FRAC fraction bits
//   data_out  out  OUT_WIDTH  rounded/saturated sample, OUT_FRAC fraction bits
//   overflow  out  1          result clipped to the positive limit
//   underflow out  1          result clipped to the negative limit
module rounding_overflow_arith #(
    parameter int ACC_WIDTH = 40,
    parameter int ACC_FRAC  = 33,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 15
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int SHIFT     = ACC_FRAC - OUT_FRAC;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int RND_WIDTH = ACC_WIDTH + 1;
    localparam int SHR_WIDTH = RND_WIDTH - SHIFT;

    localparam logic signed [RND_WIDTH-1:0] HALF    = RND_WIDTH'(1) <<< (SHIFT - 1);
    localparam logic signed [SHR_WIDTH-1:0] OUT_MAX = SHR_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SHR_WIDTH-1:0] OUT_MIN = SHR_WIDTH'(-(1 << (OUT_WIDTH - 1)));

    logic signed [RND_WIDTH-1:0] rounded;
    logic signed [SHR_WIDTH-1:0] shifted;

    always_comb begin
        rounded   = RND_WIDTH'(acc_in) + HALF;
        shifted   = SHR_WIDTH'(rounded >>> SHIFT);
        overflow  = shifted > OUT_MAX;
        underflow = shifted < OUT_MIN;
        if (overflow)
            data_out = OUT_WIDTH'(OUT_MAX);
        else if (underflow)
            data_out = OUT_WIDTH'(OUT_MIN);
        else
            data_out = OUT_WIDTH'(shifted);
    end

endmodule

// File: rtl/halfband_decimator.sv
// halfband_decimator
// Decimate-by-2 halfband FIR fed by the fractional_decimator output stream.
// A 4-entry FIFO absorbs bursty input; one pre-add/MAC datapath walks the
// seven unique coefficients serially, and one output is made per input pair.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_in        input sample strobe
//   filter_in       signed input sample (S16.15)
//   bypass          pass filter_in to filter_out (registered), abort filtering
//   coeff_wr_en     load all coefficients (honoured only when idle, no pop)
//   coeff_data_in   new coefficients, c[k] at bits [k*COEFF_WIDTH +: COEFF_WIDTH]
//   coeff_data_out  current coefficients, same packing
//   filter_out      signed result (S16.15), valid_out one-cycle strobe
//   overflow        saturation flags of the current filter_out
//   underflow
//   overrun         one-cycle pulse: sample dropped on a full FIFO
//   busy            FSM not idle
module halfband_decimator
    import dfe_hb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic signed [DATA_WIDTH-1:0]  filter_in,
    input  logic                          bypass,
    input  logic                          coeff_wr_en,
    input  logic [COEFF_WIDTH*N_UNIQ-1:0] coeff_data_in,
    output logic [COEFF_WIDTH*N_UNIQ-1:0] coeff_data_out,
    output logic signed [DATA_WIDTH-1:0]  filter_out,
    output logic                          valid_out,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          overrun,
    output logic                          busy
);

    localparam int PRE_WIDTH  = DATA_WIDTH + 1;
    localparam int PROD_WIDTH = PRE_WIDTH + COEFF_WIDTH;
    localparam int ACC_WIDTH  = 40;
    localparam int ACC_FRAC   = DATA_FRAC + COEFF_FRAC;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int K_W        = $clog2(N_UNIQ);

    hb_state_t                   state;
    logic [K_W-1:0]              k;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        phase;
    logic signed [DATA_WIDTH-1:0]  x        [N_TAP];
    logic signed [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic signed [COEFF_WIDTH-1:0] coeff    [N_UNIQ];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            fifo_cnt;

    logic fifo_full, fifo_empty, push, pop, coeff_load;
    logic signed [DATA_WIDTH-1:0]  tap_a, tap_b;
    logic signed [COEFF_WIDTH-1:0] c_sel;
    logic signed [PRE_WIDTH-1:0]   pre_sum;
    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [DATA_WIDTH-1:0]  rnd_data;
    logic                          rnd_ovf, rnd_unf;

    assign fifo_full  = fifo_cnt == CNT_W'(FIFO_DEPTH);
    assign fifo_empty = fifo_cnt == '0;
    // A full FIFO rejects the write even if a pop happens the same cycle.
    assign push       = valid_in && !fifo_full && !bypass;
    assign pop        = (state == IDLE) && !fifo_empty && !bypass;
    assign coeff_load = coeff_wr_en && (state == IDLE) && !pop;
    assign busy       = state != IDLE;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tap_a = x[(N_TAP - 1) / 2];
        tap_b = '0;
        c_sel = coeff[N_UNIQ-1];
        for (int i = 0; i < N_UNIQ - 1; i++) begin
            if (k == K_W'(i)) begin
                tap_a = x[2*i];
                tap_b = x[N_TAP-1-2*i];
                c_sel = coeff[i];
            end
        end
        pre_sum  = PRE_WIDTH'(tap_a) + PRE_WIDTH'(tap_b);
        product  = PROD_WIDTH'(pre_sum) * PROD_WIDTH'(c_sel);
        acc_next = acc + ACC_WIDTH'(product);
    end

    always_comb begin
        for (int i = 0; i < N_UNIQ; i++)
            coeff_data_out[i*COEFF_WIDTH +: COEFF_WIDTH] = coeff[i];
    end

    rounding_overflow_arith #(
        .ACC_WIDTH (ACC_WIDTH),
        .ACC_FRAC  (ACC_FRAC),
        .OUT_WIDTH (DATA_WIDTH),
        .OUT_FRAC  (DATA_FRAC)
    ) u_round (
        .acc_in    (acc),
        .data_out  (rnd_data),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    // NOTE: FIFO storage has no reset; fifo_cnt gates every read, so stale words are never used.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= filter_in;
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            phase      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            filter_out <= '0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < N_TAP; i++)
                x[i] <= '0;
            for (int i = 0; i < N_UNIQ; i++)
                coeff[i] <= COEFF_WIDTH'(DEFAULT_COEFF[i]);
        end else begin
            overrun   <= valid_in && fifo_full && !bypass;
            valid_out <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (coeff_load)
                for (int i = 0; i < N_UNIQ; i++)
                    coeff[i] <= coeff_data_in[i*COEFF_WIDTH +: COEFF_WIDTH];

            if (bypass) begin
                // Abort and flush; the delay line is deliberately kept.
                state      <= IDLE;
                k          <= '0;
                phase      <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_cnt   <= '0;
                filter_out <= filter_in;
                valid_out  <= valid_in;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            x[0] <= fifo_mem[rd_ptr];
                            for (int i = 1; i < N_TAP; i++)
                                x[i] <= x[i-1];
                            phase <= !phase;
                            // Second sample of a pair: start a new output.
                            if (phase) begin
                                acc   <= '0;
                                k     <= '0;
                                state <= MAC;
                            end
                        end
                    end
                    MAC: begin
                        acc <= acc_next;
                        if (k == K_W'(N_UNIQ - 1))
                            state <= OUT;
                        else
                            k <= k + K_W'(1);
                    end
                    OUT: begin
                        filter_out <= rnd_data;
                        overflow   <= rnd_ovf;
                        underflow  <= rnd_unf;
                        valid_out  <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_halfband_decimator.sv
// tb_halfband_decimator
// Scoreboard bench: stimulus pushes hand-computed expected outputs into a
// queue; an independent monitor pops and compares on every valid_out.
module tb_halfband_decimator;

    localparam int DW = 16;
    localparam int CW = 20;
    localparam int NU = 7;
    localparam int CV = CW * NU;

    // Power-up coefficient set, c[0] in the low bits.
    localparam logic [CV-1:0] DEF_C = {20'h20000, 20'(82000), 20'(-25000), 20'(12000),
                                       20'(-5500), 20'(2600), 20'(-564)};
    // Centre tap 0.5 only.
    localparam logic [CV-1:0] DC_C  = {20'h20000, 120'h0};
    // Centre tap ~2.0 only.
    localparam logic [CV-1:0] SAT_C = {20'h7FFFF, 120'h0};
    // Distinct taps to expose indexing and half-up rounding of +/-1.5 LSB.
    localparam logic [CV-1:0] IMP_C = {20'h20000, 20'h30000, 20'(-65536), 20'h02340,
                                       20'h01000, 20'(-24), 20'(24)};
    // c[0] = 0.25 only: output = (x[0] + x[22]) / 4.
    localparam logic [CV-1:0] C0_C  = {120'h0, 20'h10000};
    // c[1] = 0.25 only: output = (x[2] + x[20]) / 4.
    localparam logic [CV-1:0] C1_C  = {100'h0, 20'h10000, 20'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] filter_in;
    logic          bypass;
    logic          coeff_wr_en;
    logic [CV-1:0] coeff_data_in;
    logic [CV-1:0] coeff_data_out;
    logic [DW-1:0] filter_out;
    logic          valid_out, overflow, underflow, overrun, busy;

    halfband_decimator dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .filter_in      (filter_in),
        .bypass         (bypass),
        .coeff_wr_en    (coeff_wr_en),
        .coeff_data_in  (coeff_data_in),
        .coeff_data_out (coeff_data_out),
        .filter_out     (filter_out),
        .valid_out      (valid_out),
        .overflow       (overflow),
        .underflow      (underflow),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          ovf;
        logic          unf;
        int            exp_cyc;   // -1: no latency check
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass = 0;
    int overrun_cnt = 0;

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid_out: got filter_out=0x%0h, expected no output", filter_out);
            end else begin
                e = sb.pop_front();
                check("filter_out", filter_out, e.data);
                check("overflow", overflow, e.ovf);
                check("underflow", underflow, e.unf);
                if (e.exp_cyc >= 0)
                    check("latency", cyc, e.exp_cyc);
            end
        end
        if (overrun === 1'b1)
            overrun_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        bypass = 1'b0;
        coeff_wr_en = 1'b0;
        filter_in = '0;
        coeff_data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_coeffs(input logic [CV-1:0] v);
        coeff_data_in = v;
        coeff_wr_en = 1'b1;
        @(negedge clk);
        coeff_wr_en = 1'b0;
        check("coeff_load", coeff_data_out, v);
    endtask

    // One sample, then idle to keep the input rate at 1 per 5 cycles.
    task automatic drive(input logic [DW-1:0] s);
        filter_in = s;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // The second write completes the pair; its output is due 9 edges later.
    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] d, input logic o, input logic u);
        drive(a);
        sb.push_back('{d, o, u, cyc + 10});
        drive(b);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] imp_seq [12];
        logic [DW-1:0] byp_vals [3];
        imp_seq = '{16'h0002, 16'hFFFF, 16'h0100, 16'h0234, 16'hF000, 16'h3000,
                    16'h3000, 16'hF000, 16'h0234, 16'h0100, 16'hFFFF, 16'h0002};
        byp_vals = '{16'h0111, 16'hFEDC, 16'h7FFF};

        // Reset state
        do_reset();
        check("rst_filter_out", filter_out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_coeffs", coeff_data_out, DEF_C);

        // DC gain through the centre tap, latency on every output
        load_coeffs(DC_C);
        for (int i = 0; i < 8; i++)
            send_pair(16'h4000, 16'h4000, (i < 5) ? 16'h0000 : 16'h2000, 1'b0, 1'b0);
        drain();

        // Impulse as second of a pair walks the even taps; as first, hits the centre
        do_reset();
        load_coeffs(IMP_C);
        send_pair(16'h0000, 16'h4000, imp_seq[0], 1'b0, 1'b0);
        for (int i = 1; i < 12; i++)
            send_pair(16'h0000, 16'h0000, imp_seq[i], 1'b0, 1'b0);
        send_pair(16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++)
            send_pair(16'h0000, 16'h0000, (i == 5) ? 16'h2000 : 16'h0000, 1'b0, 1'b0);
        drain();

        // Positive saturation; flag holds after the strobe
        do_reset();
        load_coeffs(SAT_C);
        for (int i = 0; i < 6; i++)
            send_pair(16'h7FFF, 16'h7FFF, (i == 5) ? 16'h7FFF : 16'h0000, i == 5, 1'b0);
        drain();
        check("overflow_hold", overflow, 1);

        // Negative saturation
        do_reset();
        load_coeffs(SAT_C);
        for (int i = 0; i < 6; i++)
            send_pair(16'h8000, 16'h8000, (i == 5) ? 16'h8000 : 16'h0000, 1'b0, i == 5);
        drain();
        check("underflow_hold", underflow, 1);

        // Overrun: 8 back-to-back samples, the last two are dropped
        do_reset();
        load_coeffs(C0_C);
        overrun_cnt = 0;
        sb.push_back('{16'h0400, 1'b0, 1'b0, -1});
        sb.push_back('{16'h0800, 1'b0, 1'b0, -1});
        sb.push_back('{16'hF000, 1'b0, 1'b0, -1});
        begin
            logic [DW-1:0] burst [8];
            burst = '{16'h0100, 16'h1000, 16'h0200, 16'h2000,
                      16'h0300, 16'hC000, 16'h7000, 16'h7000};
            for (int i = 0; i < 8; i++) begin
                filter_in = burst[i];
                valid_in = 1'b1;
                @(negedge clk);
            end
            valid_in = 1'b0;
        end
        drain();
        check("overrun_pulses", overrun_cnt, 2);

        // Bypass asserted while k=3: pair aborted, delay line kept
        do_reset();
        load_coeffs(C1_C);
        drive(16'h1000);
        filter_in = 16'h2000;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_in_mac", busy, 1);
        bypass = 1'b1;
        filter_in = 16'h1234;
        @(negedge clk);
        check("bypass_busy", busy, 0);
        check("bypass_track", filter_out, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{byp_vals[i], 1'b0, 1'b0, -1});
            filter_in = byp_vals[i];
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);
        bypass = 1'b0;
        filter_in = '0;
        repeat (20) @(negedge clk);
        check("bypass_drained", sb.size(), 0);
        send_pair(16'h0400, 16'h0800, 16'h0800, 1'b0, 1'b0);
        drain();

        // Coefficient write ignored while busy, honoured when idle
        do_reset();
        load_coeffs(DC_C);
        for (int i = 0; i < 5; i++)
            send_pair(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0);
        drive(16'h4000);
        sb.push_back('{16'h2000, 1'b0, 1'b0, cyc + 10});
        filter_in = 16'h4000;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        coeff_data_in = '0;
        coeff_wr_en = 1'b1;
        @(negedge clk);
        coeff_wr_en = 1'b0;
        check("coeff_busy_ignored", coeff_data_out, DC_C);
        drain();
        load_coeffs('0);
        send_pair(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
